rf_port_sched: RTL and testbench
================================

Name: rf_port_sched

Overview:
- Schedules the single-port register file (one shared address, combinational read, synchronous write, x0 reads zero) between an operand-read requester and a writeback requester.
- Serializes the rs1 and rs2 reads over successive cycles, latches both operands, and presents them as one operand bundle.
- Writebacks take priority and stall the read sequence.
- Sits between decode/issue and the register file in the multi-cycle core.

Parameters:
WORD_SIZE, 32, data width of the register file
REG_COUNT, 32, number of architectural registers; address width AW = $clog2(REG_COUNT)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  operand-read request valid
req_ready  output  1  scheduler can accept a request
req_rs1  input  AW  first source register
req_rs2  input  AW  second source register
req_use_rs2  input  1  request needs rs2
op_valid  output  1  operand bundle valid
op_ready  input  1  consumer accepts bundle
op_a  output  WORD_SIZE  rs1 value
op_b  output  WORD_SIZE  rs2 value, 0 when use_rs2=0
wb_valid  input  1  writeback request
wb_ready  output  1  writeback accepted this cycle
wb_addr  input  AW  destination register
wb_data  input  WORD_SIZE  writeback data
rf_we  output  1  register-file write enable
rf_addr  output  AW  register-file shared address
rf_wdata  output  WORD_SIZE  register-file write data
rf_rdata  input  WORD_SIZE  register-file read data (combinational on rf_addr)

Behaviour:
- Reset (async, immediate): state=IDLE; registered op_a, op_b, rs1_q, rs2_q, use_rs2_q cleared; op_valid=0; req_ready=1.
- Registered state machine states: IDLE, RD1, RD2, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture rs1/rs2/use_rs2 into rs1_q/rs2_q/use_rs2_q and go to RD1.
  - The port is not used for reads in the accept cycle.
- RD1:
  - If wb_valid, stay in RD1; the writeback uses the port.
  - Otherwise drive rf_addr=rs1_q and latch op_a<=rf_rdata.
  - Next state: RD2 if use_rs2_q, else DONE with op_b<=0.
- RD2:
  - Same stall rule as RD1.
  - Otherwise drive rf_addr=rs2_q, latch op_b<=rf_rdata, go to DONE.
- DONE:
  - op_valid=1; op_a/op_b held stable until op_ready.
  - On op_ready, go to IDLE.
  - req_ready=0 in DONE; no back-to-back overlap.
- req_ready=0 in RD1, RD2 and DONE. op_valid is 1 only in DONE.
- Writeback arbitration:
  - wb_ready=1 whenever wb_valid=1, in every state; writeback always has priority.
  - A writeback completes in the cycle it is presented: rf_addr=wb_addr, rf_wdata=wb_data.
  - rf_we=wb_valid && (wb_addr!=0). A write to x0 is acknowledged but suppressed.
- Port defaults when idle and no writeback: rf_we=0, rf_addr=0, rf_wdata=0.
- Ordering:
  - A writeback in the same cycle as a pending RD1/RD2 completes first.
  - The later read therefore returns the new value with no explicit bypass.
  - Values already latched into op_a/op_b are not updated by later writebacks; the issuing stage owns that hazard.
- Latency (no writebacks):
  - Accept at cycle T; op_valid at T+2 with one operand, T+3 with two.
  - Each writeback cycle during RD1/RD2 adds exactly one cycle.
- Reading x0 uses a port cycle like any other register; op value is 0.
- Reset asserted mid-sequence aborts it: no rf_we glitch, op_valid drops immediately, and the request is lost.
- rf_we, rf_addr and rf_wdata are combinational from state and wb_*. No combinational path from rf_rdata to any output.

Test Plan:
- Two-operand read: preload x3=0x11, x7=0x22. Request rs1=3, rs2=7, use_rs2=1 at T → rf_addr=3 at T+1, 7 at T+2; op_valid at T+3 with op_a=0x11, op_b=0x22; req_ready=0 during T+1..T+3.
- Single-operand read: rs1=5 (=0xABCD), use_rs2=0 → op_valid at T+2, op_a=0xABCD, op_b=0; exactly one read port cycle.
- Writeback collision: wb_valid with addr=7, data=0x99 during RD2 → rf_we=1 that cycle, RD2 repeats next cycle; op_b=0x99; op_valid delayed to T+4.
- x0 write: wb_valid with addr=0, data=0xFFFF → wb_ready=1, rf_we=0; subsequent read of rs1=0 gives op_a=0.
- Backpressure: hold op_ready=0 for 5 cycles in DONE while writing x3=0x55 → op_a stays 0x11, req_ready=0; op_ready=1 → IDLE, req_ready=1 next cycle.
- Async reset: assert rst mid-RD1 between clock edges → op_valid=0, req_ready=1, rf_we=0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/rf_port_sched_if.sv
// Handshake and register-file port bundle for the operand-read / writeback scheduler.
// The scheduler takes the slave side; the core/bench drives the master side.
interface rf_port_sched_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32
);
    localparam int AW = $clog2(REG_COUNT);

    logic                 req_valid;
    logic                 req_ready;
    logic [AW-1:0]        req_rs1;
    logic [AW-1:0]        req_rs2;
    logic                 req_use_rs2;

    logic                 op_valid;
    logic                 op_ready;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [AW-1:0]        wb_addr;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 rf_we;
    logic [AW-1:0]        rf_addr;
    logic [WORD_SIZE-1:0] rf_wdata;
    logic [WORD_SIZE-1:0] rf_rdata;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2,
        output req_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output rf_we, rf_addr, rf_wdata,
        input  rf_rdata
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2,
        input  req_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  rf_we, rf_addr, rf_wdata,
        output rf_rdata
    );
endinterface

// File: rtl/rf_port_sched.sv
// Shares one register-file port between serialized rs1/rs2 operand reads and
// writebacks; writebacks always win and simply stretch the read sequence.
module rf_port_sched #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    rf_port_sched_if.slave  bus
);
    localparam int AW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

    state_t               state, state_n;
    logic [AW-1:0]        rs1_q, rs2_q;
    logic                 use_rs2_q;
    logic [WORD_SIZE-1:0] op_a_q, op_b_q;

    logic cap, ld_a, ld_b, clr_b;
    logic rf_we_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state <= state_n;
            if (cap) begin
                rs1_q     <= bus.req_rs1;
                rs2_q     <= bus.req_rs2;
                use_rs2_q <= bus.req_use_rs2;
            end
            if (ld_a)
                op_a_q <= bus.rf_rdata;
            if (ld_b)
                op_b_q <= bus.rf_rdata;
            else if (clr_b)
                op_b_q <= '0;
        end
    end

    always_comb begin
        state_n       = state;
        cap           = 1'b0;
        ld_a          = 1'b0;
        ld_b          = 1'b0;
        clr_b         = 1'b0;
        rf_we_c       = 1'b0;
        bus.rf_addr   = '0;
        bus.rf_wdata  = '0;
        bus.req_ready = 1'b0;
        bus.op_valid  = 1'b0;

        // Writeback owns the port whenever present; reads below only run when it is absent.
        if (bus.wb_valid) begin
            bus.rf_addr  = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
            rf_we_c      = (bus.wb_addr != '0);
        end

        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    cap     = 1'b1;
                    state_n = RD1;
                end
            end
            RD1: begin
                if (!bus.wb_valid) begin
                    bus.rf_addr = rs1_q;
                    ld_a        = 1'b1;
                    clr_b       = !use_rs2_q;
                    state_n     = use_rs2_q ? RD2 : DONE;
                end
            end
            RD2: begin
                if (!bus.wb_valid) begin
                    bus.rf_addr = rs2_q;
                    ld_b        = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                bus.op_valid = 1'b1;
                if (bus.op_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Held-off during reset so an aborted sequence can never produce a stray write.
    assign bus.rf_we    = rf_we_c && !rst;
    assign bus.wb_ready = bus.wb_valid;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
endmodule

// File: tb/tb_rf_port_sched.sv
// Self-checking bench for rf_port_sched: table of read requests plus hand-written
// collision, x0, backpressure and async-reset sequences against a behavioural regfile.
module tb_rf_port_sched;
    localparam int WORD_SIZE = 32;
    localparam int REG_COUNT = 32;
    localparam int AW = $clog2(REG_COUNT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_port_sched_if #(.WORD_SIZE(WORD_SIZE), .REG_COUNT(REG_COUNT)) bus ();

    rf_port_sched #(.WORD_SIZE(WORD_SIZE), .REG_COUNT(REG_COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port register file: combinational read, synchronous write, x0 = 0.
    logic [WORD_SIZE-1:0] rf_mem [REG_COUNT];
    always @(posedge clk)
        if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
    assign bus.rf_rdata = (bus.rf_addr == '0) ? '0 : rf_mem[bus.rf_addr];

    typedef struct {
        logic [AW-1:0]        rs1;
        logic [AW-1:0]        rs2;
        logic                 use_rs2;
        logic [WORD_SIZE-1:0] exp_a;
        logic [WORD_SIZE-1:0] exp_b;
        int                   exp_lat;
    } vec_t;

    typedef struct {
        logic [WORD_SIZE-1:0] a;
        logic [WORD_SIZE-1:0] b;
        int                   lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [WORD_SIZE-1:0] d);
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        #1;
        chk("wb_ready", 32'(bus.wb_ready), 32'd1);
        chk("wb_rf_we", 32'(bus.rf_we), (a != 0) ? 32'd1 : 32'd0);
        if (a != 0) begin
            chk("wb_rf_addr", 32'(bus.rf_addr), 32'(a));
            chk("wb_rf_wdata", bus.rf_wdata, d);
        end
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Drives the accept cycle (cycle 0); returns positioned in cycle 1.
    task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u,
                         input logic [WORD_SIZE-1:0] ea, input logic [WORD_SIZE-1:0] eb,
                         input int elat);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_rs1 = r1; bus.req_rs2 = r2; bus.req_use_rs2 = u;
        e.a = ea; e.b = eb; e.lat = elat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1;
    endtask

    // Waits (bounded) for the bundle, scores it against the queue head, then accepts it.
    task automatic collect();
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!bus.op_valid && guard < 20) begin
            @(posedge clk); #1; cyc++; guard++;
            @(negedge clk);
        end
        if (!bus.op_valid) begin
            n_chk++; n_fail++;
            $display("FAIL op_valid_timeout: got 0 expected 1 within 20 cycles");
        end
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty: got bundle expected none");
        end else begin
            e = sb.pop_front();
            chk("op_a", bus.op_a, e.a);
            chk("op_b", bus.op_b, e.b);
            chk("latency", 32'(cyc), 32'(e.lat));
        end
        chk("req_ready_done", 32'(bus.req_ready), 32'd0);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("op_valid_after", 32'(bus.op_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_use_rs2 = 0;
        bus.op_ready = 0; bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;

        vecs[0] = '{rs1: 5'd3, rs2: 5'd7, use_rs2: 1'b1, exp_a: 32'h11,   exp_b: 32'h22,   exp_lat: 3};
        vecs[1] = '{rs1: 5'd5, rs2: 5'd0, use_rs2: 1'b0, exp_a: 32'hABCD, exp_b: 32'h0,    exp_lat: 2};
        vecs[2] = '{rs1: 5'd0, rs2: 5'd0, use_rs2: 1'b0, exp_a: 32'h0,    exp_b: 32'h0,    exp_lat: 2};
        vecs[3] = '{rs1: 5'd7, rs2: 5'd3, use_rs2: 1'b1, exp_a: 32'h22,   exp_b: 32'h11,   exp_lat: 3};
        vecs[4] = '{rs1: 5'd9, rs2: 5'd9, use_rs2: 1'b1, exp_a: 32'h1234, exp_b: 32'h1234, exp_lat: 3};
        vecs[5] = '{rs1: 5'd3, rs2: 5'd9, use_rs2: 1'b0, exp_a: 32'h11,   exp_b: 32'h0,    exp_lat: 2};

        // Reset state
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_op_b", bus.op_b, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Preload through the writeback path; the x0 write must be acked but suppressed.
        wb_write(5'd3, 32'h11);
        wb_write(5'd7, 32'h22);
        wb_write(5'd5, 32'hABCD);
        wb_write(5'd9, 32'h1234);
        wb_write(5'd0, 32'hFFFF);

        foreach (vecs[i]) begin
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].use_rs2,
                  vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_lat);
            @(negedge clk);
            chk($sformatf("v%0d_rf_addr_rs1", i), 32'(bus.rf_addr), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_req_ready_rd", i), 32'(bus.req_ready), 32'd0);
            if (vecs[i].use_rs2) begin
                @(posedge clk); #1; cyc++;
                @(negedge clk);
                chk($sformatf("v%0d_rf_addr_rs2", i), 32'(bus.rf_addr), 32'(vecs[i].rs2));
            end
            @(posedge clk); #1; cyc++;
            collect();
        end

        // Writeback to x7 collides with RD2: RD2 repeats and sees the new value.
        issue(5'd3, 5'd7, 1'b1, 32'h11, 32'h99, 4);
        @(negedge clk);
        chk("col_rf_addr_rs1", 32'(bus.rf_addr), 32'd3);
        @(posedge clk); #1; cyc++;
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h99;
        #1;
        chk("col_rf_we", 32'(bus.rf_we), 32'd1);
        chk("col_rf_addr_wb", 32'(bus.rf_addr), 32'd7);
        chk("col_rf_wdata", bus.rf_wdata, 32'h99);
        chk("col_wb_ready", 32'(bus.wb_ready), 32'd1);
        @(posedge clk); #1; cyc++;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("col_rd2_retry_addr", 32'(bus.rf_addr), 32'd7);
        chk("col_rd2_retry_we", 32'(bus.rf_we), 32'd0);
        chk("col_op_valid_early", 32'(bus.op_valid), 32'd0);
        @(posedge clk); #1; cyc++;
        collect();

        // Backpressure: bundle held while x3 is overwritten underneath it.
        issue(5'd3, 5'd0, 1'b0, 32'h11, 32'h0, 2);
        @(posedge clk); #1; cyc++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
                #1;
                chk("bp_wb_rf_we", 32'(bus.rf_we), 32'd1);
            end
            chk("bp_op_valid", 32'(bus.op_valid), 32'd1);
            chk("bp_op_a_hold", bus.op_a, 32'h11);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            bus.wb_valid = 1'b0;
        end
        cyc = 2;
        collect();

        // Async reset mid-RD1 aborts the request.
        issue(5'd7, 5'd3, 1'b1, 32'h99, 32'h55, 3);
        #2;
        chk("ar_rf_addr_pre", 32'(bus.rf_addr), 32'd7);
        rst = 1'b1;
        #1;
        chk("ar_op_valid", 32'(bus.op_valid), 32'd0);
        chk("ar_req_ready", 32'(bus.req_ready), 32'd1);
        chk("ar_rf_we", 32'(bus.rf_we), 32'd0);
        chk("ar_rf_addr", 32'(bus.rf_addr), 32'd0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("ar_op_a_clr", bus.op_a, 32'd0);

        // Reset in DONE drops op_valid without waiting for a clock.
        issue(5'd5, 5'd0, 1'b0, 32'hABCD, 32'h0, 2);
        @(posedge clk); #3;
        chk("ard_op_valid_pre", 32'(bus.op_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("ard_op_valid", 32'(bus.op_valid), 32'd0);
        chk("ard_req_ready", 32'(bus.req_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after reset.
        issue(5'd7, 5'd3, 1'b1, 32'h99, 32'h55, 3);
        @(posedge clk); #1; cyc++;
        @(posedge clk); #1; cyc++;
        collect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
